// File: rtl/surf5_spi_wb_bridge_if.sv
// WISHBONE bus bundle between the surf5 SPI bridge (initiator) and its slaves.
// Single 32-bit classic cycles; stb always follows cyc.
interface surf5_spi_wb_bridge_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/surf5_spi_wb_bridge.sv
// SPI slave (mode 0) to WISHBONE master bridge for the surf5 register bus.
// SCK, CS_B and MOSI are oversampled in clk_i; every frame issues at most one
// 32-bit bus cycle. Write frame: CMD, ADDR_HI, ADDR_LO, 4 data bytes.
// Read frame: CMD, ADDR_HI, ADDR_LO, turnaround byte, 4 data bytes on MISO.
module surf5_spi_wb_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 48
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         spi_sck_i,
  input  logic                         spi_cs_b_i,
  input  logic                         spi_mosi_i,
  output logic                         spi_miso_o,
  output logic                         spi_miso_oe_o,
  surf5_spi_wb_bridge_if.master        wbm,
  output logic                         busy_o,
  output logic                         err_o
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CMD     = 4'd1,
    ST_ADDR    = 4'd2,
    ST_WDATA   = 4'd3,
    ST_WB_WR   = 4'd4,
    ST_WB_RD   = 4'd5,
    ST_TURN    = 4'd6,
    ST_RDATA   = 4'd7,
    ST_WAIT_CS = 4'd8
  } state_t;

  // Last timer value before the bus cycle is abandoned.
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

  // Synchroniser chains and edge-detect history.
  logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q,  sck_prev_d;
  logic                   cs_prev_q,   cs_prev_d;

  logic sck_s;
  logic cs_b_s;
  logic mosi_s;
  logic sck_rise_s;
  logic sck_fall_s;
  logic cs_fall_s;
  logic cs_rise_s;

  // Frame state.
  state_t      state_q,    state_d;
  logic [5:0]  bit_cnt_q,  bit_cnt_d;
  logic [30:0] shift_q,    shift_d;
  logic        we_q,       we_d;
  logic [15:0] adr_q,      adr_d;
  logic [31:0] wdat_q,     wdat_d;
  logic [31:0] rdat_q,     rdat_d;
  logic        cyc_q,      cyc_d;
  logic [5:0]  tmo_q,      tmo_d;
  logic        miso_q,     miso_d;
  logic        err_q,      err_d;
  logic        busy_q,     busy_d;
  logic        cs_lost_q,  cs_lost_d;
  logic        err_done_q, err_done_d;

  logic bus_ok_s;
  logic bus_end_s;
  logic bus_bad_s;
  logic cs_gone_s;
  logic flag_err_s;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign cs_b_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_q;
  assign sck_fall_s = ~sck_s & sck_prev_q;
  assign cs_fall_s  = ~cs_b_s & cs_prev_q;
  assign cs_rise_s  = cs_b_s & ~cs_prev_q;

  // Bus termination: ack ends cleanly, err/rty/timeout end with an error.
  assign bus_ok_s  = cyc_q & wbm.ack;
  assign bus_end_s = cyc_q & (wbm.ack | wbm.err | wbm.rty | (tmo_q == TMO_LAST));
  assign bus_bad_s = bus_end_s & ~wbm.ack;
  // CS_B went high at some point while the bus cycle was in flight.
  assign cs_gone_s = cs_lost_q | cs_rise_s;

  // Next values for the input synchronisers and edge history.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  spi_sck_i};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_b_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_b_s;
  end

  // Synchroniser registers; CS_B resets to its idle-high level so no frame starts at reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  // Frame decoder, bus cycle control and MISO shifter.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    rdat_d     = rdat_q;
    cyc_d      = cyc_q;
    tmo_d      = tmo_q;
    miso_d     = miso_q;
    err_d      = 1'b0;
    cs_lost_d  = cs_lost_q;
    err_done_d = err_done_q;
    flag_err_s = 1'b0;

    // MOSI is collected on every synced rise; only CMD/ADDR/WDATA consume it.
    if (sck_rise_s) begin
      shift_d = {shift_q[29:0], mosi_s};
    end else begin
      shift_d = shift_q;
    end

    // Bus cycle watchdog: counts while cyc is high, clears when it drops.
    if (cyc_q) begin
      if (bus_end_s) begin
        cyc_d = 1'b0;
        tmo_d = 6'd0;
      end else begin
        tmo_d = tmo_q + 6'd1;
      end
    end else begin
      tmo_d = 6'd0;
    end

    case (state_q)
      ST_IDLE: begin
        miso_d     = 1'b0;
        cs_lost_d  = 1'b0;
        err_done_d = 1'b0;
        bit_cnt_d  = 6'd0;
        if (cs_fall_s) begin
          state_d = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CMD: begin
        if (cs_rise_s) begin
          state_d    = ST_IDLE;
          miso_d     = 1'b0;
          flag_err_s = 1'b1;
        end else if (sck_rise_s) begin
          // First bit of the command byte selects write (1) or read (0).
          if (bit_cnt_q == 6'd0) begin
            we_d = mosi_s;
          end else begin
            we_d = we_q;
          end
          if (bit_cnt_q == 6'd7) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 6'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_ADDR: begin
        if (cs_rise_s) begin
          state_d    = ST_IDLE;
          miso_d     = 1'b0;
          flag_err_s = 1'b1;
        end else if (sck_rise_s) begin
          if (bit_cnt_q == 6'd15) begin
            adr_d     = {shift_q[14:0], mosi_s};
            bit_cnt_d = 6'd0;
            if (we_q) begin
              state_d = ST_WDATA;
            end else begin
              // Reads start the bus cycle now so data is ready by the turnaround.
              state_d = ST_WB_RD;
              cyc_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_WDATA: begin
        if (cs_rise_s) begin
          // Partial write data is dropped; no bus cycle is issued.
          state_d    = ST_IDLE;
          miso_d     = 1'b0;
          flag_err_s = 1'b1;
        end else if (sck_rise_s) begin
          if (bit_cnt_q == 6'd31) begin
            wdat_d    = {shift_q[30:0], mosi_s};
            bit_cnt_d = 6'd0;
            state_d   = ST_WB_WR;
            cyc_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_WB_WR: begin
        if (cs_rise_s) begin
          cs_lost_d = 1'b1;
        end else begin
          cs_lost_d = cs_lost_q;
        end
        if (bus_end_s) begin
          flag_err_s = bus_bad_s | cs_gone_s;
          if (cs_gone_s) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
          end else begin
            state_d = ST_WAIT_CS;
          end
        end else begin
          state_d = ST_WB_WR;
        end
      end

      ST_WB_RD: begin
        if (cs_rise_s) begin
          cs_lost_d = 1'b1;
        end else begin
          cs_lost_d = cs_lost_q;
        end
        // Turnaround rises are counted while the bus cycle is still running.
        if (sck_rise_s && (bit_cnt_q < 6'd8)) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        if (bus_end_s) begin
          rdat_d     = bus_ok_s ? wbm.dat_r : 32'hFFFF_FFFF;
          flag_err_s = bus_bad_s | cs_gone_s;
          if (cs_gone_s) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
          end else begin
            state_d = ST_TURN;
          end
        end else begin
          state_d = ST_WB_RD;
        end
      end

      ST_TURN: begin
        if (cs_rise_s) begin
          state_d    = ST_IDLE;
          miso_d     = 1'b0;
          flag_err_s = 1'b1;
        end else if (bit_cnt_q >= 6'd8) begin
          state_d   = ST_RDATA;
          bit_cnt_d = 6'd0;
        end else if (sck_rise_s) begin
          if (bit_cnt_q == 6'd7) begin
            state_d   = ST_RDATA;
            bit_cnt_d = 6'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_RDATA: begin
        if (cs_rise_s) begin
          state_d    = ST_IDLE;
          miso_d     = 1'b0;
          flag_err_s = 1'b1;
        end else if (sck_fall_s) begin
          // Each fall presents the next bit, MSB first.
          miso_d = rdat_q[31];
          rdat_d = {rdat_q[30:0], 1'b0};
        end else if (sck_rise_s) begin
          if (bit_cnt_q == 6'd31) begin
            state_d = ST_WAIT_CS;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ST_WAIT_CS: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end else begin
          state_d = ST_WAIT_CS;
        end
      end

      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
        cyc_d   = 1'b0;
      end
    endcase

    // At most one error pulse per frame.
    if (flag_err_s && !err_done_q) begin
      err_d      = 1'b1;
      err_done_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Frame state and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 6'd0;
      shift_q    <= 31'd0;
      we_q       <= 1'b0;
      adr_q      <= 16'd0;
      wdat_q     <= 32'd0;
      rdat_q     <= 32'd0;
      cyc_q      <= 1'b0;
      tmo_q      <= 6'd0;
      miso_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      cs_lost_q  <= 1'b0;
      err_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      rdat_q     <= rdat_d;
      cyc_q      <= cyc_d;
      tmo_q      <= tmo_d;
      miso_q     <= miso_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      cs_lost_q  <= cs_lost_d;
      err_done_q <= err_done_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = ~cs_b_s;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = cyc_q;
  assign wbm.we    = we_q;
  assign wbm.adr   = adr_q;
  assign wbm.dat_w = wdat_q;
  assign wbm.sel   = {4{cyc_q}};

endmodule

// File: tb/tb_surf5_spi_wb_bridge.sv
// Self-checking bench for surf5_spi_wb_bridge: directed frames from the
// block's test list plus randomized frames checked against a frame-level model.
module tb_surf5_spi_wb_bridge;

  localparam int SCK_HALF = 5;   // clk_i cycles per SCK half period
  localparam int TMO      = 48;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic spi_sck  = 1'b0;
  logic spi_cs_b = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic spi_miso_oe;
  logic busy;
  logic err;

  surf5_spi_wb_bridge_if wb();

  surf5_spi_wb_bridge #(.SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .spi_sck_i     (spi_sck),
    .spi_cs_b_i    (spi_cs_b),
    .spi_mosi_i    (spi_mosi),
    .spi_miso_o    (spi_miso),
    .spi_miso_oe_o (spi_miso_oe),
    .wbm           (wb),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // WB slave configuration: 0 ack, 1 err, 2 rty, 3 no response.
  int          rsp_mode = 0;
  int          rsp_lat  = 1;
  logic [31:0] rsp_data = 32'd0;

  // WB slave observations.
  int          cyc_starts = 0;
  int          cyc_len    = 0;
  int          bus_viol   = 0;
  logic [15:0] cap_adr    = 16'd0;
  logic [31:0] cap_dat    = 32'd0;
  logic        cap_we     = 1'b0;
  logic        in_cyc     = 1'b0;

  int err_seen = 0;
  int oe_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // WB slave: responds rsp_lat clocks into the cycle and watches bus stability.
  initial begin
    wb.ack   = 1'b0;
    wb.err   = 1'b0;
    wb.rty   = 1'b0;
    wb.dat_r = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (wb.cyc === 1'b1) begin
        if (!in_cyc) begin
          in_cyc = 1'b1;
          cyc_starts++;
          cap_adr = wb.adr;
          cap_dat = wb.dat_w;
          cap_we  = wb.we;
          cyc_len = 0;
        end else if (wb.adr !== cap_adr || wb.dat_w !== cap_dat || wb.we !== cap_we) begin
          bus_viol++;
        end
        if (wb.sel !== 4'hF || wb.stb !== 1'b1) bus_viol++;
        cyc_len++;
        wb.ack   = 1'b0;
        wb.err   = 1'b0;
        wb.rty   = 1'b0;
        wb.dat_r = 32'hDEAD_BEEF;
        if (cyc_len == rsp_lat) begin
          case (rsp_mode)
            0: begin wb.ack = 1'b1; wb.dat_r = rsp_data; end
            1: wb.err = 1'b1;
            2: wb.rty = 1'b1;
            default: ;
          endcase
        end
      end else begin
        in_cyc = 1'b0;
        wb.ack = 1'b0;
        wb.err = 1'b0;
        wb.rty = 1'b0;
      end
    end
  end

  // Count err_o pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (err === 1'b1) err_seen++;
    end
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One mode-0 byte: MOSI set while SCK low, MISO sampled just before the rise.
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      wait_clks(SCK_HALF);
      rx[i] = spi_miso;
      if (spi_miso_oe !== 1'b1) oe_bad++;
      spi_sck = 1'b1;
      wait_clks(SCK_HALF);
      spi_sck = 1'b0;
    end
  endtask

  // Run one frame (possibly truncated to nbytes) and check it against the frame model.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [15:0] adr,
                           input logic [31:0] wd, input int nbytes, input int hold, input int gap);
    logic [7:0]  tx [8];
    logic [7:0]  rx [8];
    logic [7:0]  side;
    logic        wr;
    logic        exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          flen;
    int          err0;
    int          cyc0;

    wr    = cmd[7];
    flen  = wr ? 7 : 8;
    tx[0] = cmd;
    tx[1] = adr[15:8];
    tx[2] = adr[7:0];
    for (int b = 3; b < 8; b++) tx[b] = 8'($urandom);
    if (wr) begin
      tx[3] = wd[31:24];
      tx[4] = wd[23:16];
      tx[5] = wd[15:8];
      tx[6] = wd[7:0];
    end
    for (int b = 0; b < 8; b++) rx[b] = 8'h00;

    err0   = err_seen;
    cyc0   = cyc_starts;
    oe_bad = 0;

    spi_cs_b = 1'b0;
    wait_clks(SCK_HALF);
    for (int b = 0; b < nbytes; b++) spi_byte(tx[b], rx[b]);
    wait_clks(hold);
    spi_cs_b = 1'b1;
    wait_clks(gap);

    // Frame-level expectations.
    exp_cyc = wr ? (nbytes == 7) : (nbytes >= 3);
    exp_err = (nbytes < flen) || (exp_cyc && rsp_mode != 0);
    exp_rd  = (rsp_mode == 0) ? rsp_data : 32'hFFFF_FFFF;

    check_eq({tag, "_cycles"}, 32'(cyc_starts - cyc0), {31'd0, exp_cyc});
    check_eq({tag, "_errpulses"}, 32'(err_seen - err0), {31'd0, exp_err});
    if (exp_cyc) begin
      check_eq({tag, "_adr"}, {16'd0, cap_adr}, {16'd0, adr});
      check_eq({tag, "_we"}, {31'd0, cap_we}, {31'd0, wr});
      if (wr) check_eq({tag, "_wdat"}, cap_dat, wd);
      check_eq({tag, "_cyclen"}, 32'(cyc_len), (rsp_mode == 3) ? 32'(TMO) : 32'(rsp_lat));
    end
    if (!wr && nbytes == 8) begin
      check_eq({tag, "_rdat"}, {rx[4], rx[5], rx[6], rx[7]}, exp_rd);
    end
    side = 8'h00;
    for (int b = 0; b < nbytes; b++) begin
      if (wr || b < 4) side = side | rx[b];
    end
    check_eq({tag, "_miso_idle"}, {24'd0, side}, 32'd0);
    check_eq({tag, "_oe"}, 32'(oe_bad), 32'd0);
    check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_busviol"}, 32'(bus_viol), 32'd0);
  endtask

  initial begin
    logic [7:0]  rxb;
    logic [7:0]  cmd;
    logic [15:0] adr;
    logic [31:0] wd;
    int          r;
    int          nb;
    int          err0;

    // Reset state.
    wait_clks(3);
    check_eq("rst_cyc",  {31'd0, wb.cyc},      32'd0);
    check_eq("rst_stb",  {31'd0, wb.stb},      32'd0);
    check_eq("rst_miso", {31'd0, spi_miso},    32'd0);
    check_eq("rst_oe",   {31'd0, spi_miso_oe}, 32'd0);
    check_eq("rst_busy", {31'd0, busy},        32'd0);
    check_eq("rst_err",  {31'd0, err},         32'd0);
    rst_n = 1'b1;
    wait_clks(5);

    // Plain write.
    rsp_mode = 0; rsp_lat = 2;
    run_frame("wr_basic", 8'h80, 16'h0018, 32'h1234_5678, 7, 70, 12);

    // Read with ack after 3 clocks.
    rsp_mode = 0; rsp_lat = 3; rsp_data = 32'h5335_4137;
    run_frame("rd_basic", 8'h00, 16'h0000, 32'd0, 8, 70, 12);

    // Read with no response: timeout, error, all-ones data.
    rsp_mode = 3;
    run_frame("rd_timeout", 8'h00, 16'h0004, 32'd0, 8, 70, 12);

    // Write cut after two data bytes, then a normal frame.
    rsp_mode = 0; rsp_lat = 1;
    run_frame("wr_trunc", 8'h80, 16'h0020, 32'hAABB_CCDD, 5, 70, 12);
    run_frame("wr_after_trunc", 8'h80, 16'h0024, 32'hCAFE_F00D, 7, 70, 12);

    // Retry on write.
    rsp_mode = 2; rsp_lat = 1;
    run_frame("wr_rty", 8'h80, 16'h0030, 32'h0BAD_0BAD, 7, 70, 12);

    // Back-to-back frames with one SCK period between them.
    rsp_mode = 0; rsp_lat = 1; rsp_data = 32'h0123_4567;
    run_frame("b2b_wr", 8'h80, 16'h0040, 32'h8765_4321, 7, SCK_HALF, 2 * SCK_HALF);
    run_frame("b2b_rd", 8'h00, 16'h0044, 32'd0, 8, SCK_HALF, 2 * SCK_HALF);

    // CS_B rises while the read bus cycle is still pending.
    rsp_mode = 3;
    run_frame("rd_cs_in_wb", 8'h00, 16'h0050, 32'd0, 3, SCK_HALF, 60);

    // Asynchronous reset during the read bus cycle.
    rsp_mode = 3;
    err0 = err_seen;
    spi_cs_b = 1'b0;
    wait_clks(SCK_HALF);
    spi_byte(8'h00, rxb);
    spi_byte(8'h00, rxb);
    spi_byte(8'h60, rxb);
    for (int i = 0; i < 40 && wb.cyc !== 1'b1; i++) wait_clks(1);
    check_eq("rstmid_cyc_seen", {31'd0, wb.cyc}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_cyc",  {31'd0, wb.cyc},   32'd0);
    check_eq("rstmid_stb",  {31'd0, wb.stb},   32'd0);
    check_eq("rstmid_miso", {31'd0, spi_miso}, 32'd0);
    check_eq("rstmid_busy", {31'd0, busy},     32'd0);
    spi_cs_b = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(10);
    check_eq("rstmid_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("rstmid_noerr", 32'(err_seen - err0), 32'd0);
    rsp_mode = 0; rsp_lat = 2; rsp_data = 32'h7777_1111;
    run_frame("after_rst", 8'h00, 16'h0064, 32'd0, 8, 70, 12);

    // Randomized frames.
    for (int k = 0; k < 20; k++) begin
      cmd = {1'($urandom_range(0, 1)), 7'($urandom)};
      adr = 16'($urandom);
      wd  = $urandom;
      r   = $urandom_range(0, 9);
      rsp_mode = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
      rsp_lat  = $urandom_range(1, 10);
      rsp_data = $urandom;
      nb = cmd[7] ? 7 : 8;
      if ($urandom_range(0, 4) == 0) nb = $urandom_range(1, nb - 1);
      run_frame($sformatf("rand%0d", k), cmd, adr, wd, nb, 70, 12);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
